// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory arbiter; define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties with MAX_BURST limit, else port 0 has fixed priority
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {NONE, P0, P1} owner_t;
  owner_t      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        sel0, sel1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;
  logic        at_limit;
  assign at_limit = cnt_q >= 4'(MAX_BURST);
  // Contested cycles: owner keeps the port until its burst is spent; from idle the port not served last wins
  always_comb begin
    sel0 = req0 && (!req1 || (owner_q == P0 ? !at_limit : owner_q == P1 ? at_limit : last_q));
    sel1 = req1 && !sel0;
  end
  assign last_d = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
  // Last-served pointer (1 = port 1); its reset value makes port 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // Port 0 wins every conflict and pre-empts port 1
  always_comb begin
    sel0 = req0;
    sel1 = req1 && !req0;
  end
`endif
  assign gnt0 = sel0 && !reset;
  assign gnt1 = sel1 && !reset;
  // Memory request muxed from the granted port, all zero when nobody holds the grant
  always_comb begin
    mem_we    = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
    mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  end
  // Next owner, burst count (wraps to 1 past MAX_BURST) and read capture
  always_comb begin
    owner_d   = gnt0 ? P0 : gnt1 ? P1 : NONE;
    cnt_d     = !(gnt0 || gnt1) ? 4'd0 :
                (owner_d == owner_q && cnt_q < 4'(MAX_BURST)) ? cnt_q + 4'd1 : 4'd1;
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end
  // Arbiter state and registered read responses; reset also cancels any pending rvalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= NONE;
      cnt_q     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
endmodule
